// File: rtl/wb_scheduler_pkg.sv
// rtl/wb_scheduler_pkg.sv - shared widths, requester encoding and helpers for the writeback scheduler
package wb_scheduler_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_idx_e;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
        addr_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester arbiter, round-robin or fixed LSU priority, one-hot grant
module rr_arb2
    import wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rr_mode,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_idx_e last_q;
    req_idx_e last_d;

    // Reset to LSU so the ALU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= REQ_LSU;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (req[REQ_ALU] && req[REQ_LSU]) begin
            if (rr_mode && (last_q == REQ_LSU)) begin
                gnt[REQ_ALU] = 1'b1;
            end else begin
                gnt[REQ_LSU] = 1'b1;
            end
        end else begin
            gnt = req;
        end
        if (gnt[REQ_ALU]) begin
            last_d = REQ_ALU;
        end else if (gnt[REQ_LSU]) begin
            last_d = REQ_LSU;
        end
    end

endmodule

// File: rtl/wb_scheduler.sv
// rtl/wb_scheduler.sv - ALU/LSU writeback arbitration, registered regfile write port and busy scoreboard
module wb_scheduler
    import wb_scheduler_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_issue_en,
    input  logic                  i_issue_rs1_en,
    input  logic [REG_ADDR_W-1:0] i_issue_rs1_addr,
    input  logic                  i_issue_rs2_en,
    input  logic [REG_ADDR_W-1:0] i_issue_rs2_addr,
    input  logic                  i_issue_wd_en,
    input  logic [REG_ADDR_W-1:0] i_issue_wd_addr,
    output logic                  o_stall,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_addr,
    input  logic [REG_DATA_W-1:0] i_alu_data,
    output logic                  o_alu_ready,
    input  logic                  i_lsu_valid,
    input  logic [REG_ADDR_W-1:0] i_lsu_addr,
    input  logic [REG_DATA_W-1:0] i_lsu_data,
    output logic                  o_lsu_ready,
    output logic                  o_wreg_en,
    output logic [REG_ADDR_W-1:0] o_wreg_addr,
    output logic [REG_DATA_W-1:0] o_wreg_data
);

    localparam logic RR_MODE = (RR_EN != 0);
    localparam logic [NUM_REGS-1:0] KEEP_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  any_gnt;
    logic [REG_ADDR_W-1:0] win_addr;
    logic [REG_DATA_W-1:0] win_data;

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   clr_vec;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   eff_busy;
    logic                  hazard;
    logic                  issue_fire;

    // Requests are masked during reset so neither ready can rise.
    assign req = {i_lsu_valid, i_alu_valid} & {2{~rst}};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .rr_mode (RR_MODE),
        .req     (req),
        .gnt     (gnt)
    );

    assign o_alu_ready = gnt[REQ_ALU];
    assign o_lsu_ready = gnt[REQ_LSU];
    assign any_gnt     = |gnt;
    assign win_addr    = gnt[REQ_LSU] ? i_lsu_addr : i_alu_addr;
    assign win_data    = gnt[REQ_LSU] ? i_lsu_data : i_alu_data;

    // Writes to x0 are accepted from the requester but never reach the regfile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wreg_en   <= 1'b0;
            o_wreg_addr <= '0;
            o_wreg_data <= '0;
        end else begin
            o_wreg_en <= any_gnt && (win_addr != '0);
            if (any_gnt) begin
                o_wreg_addr <= win_addr;
                o_wreg_data <= win_data;
            end
        end
    end

    // The regfile bypasses the write in flight, so its bit no longer blocks issue.
    assign clr_vec  = o_wreg_en ? addr_onehot(o_wreg_addr) : '0;
    assign eff_busy = busy_q & ~clr_vec;

    assign hazard = (i_issue_rs1_en && eff_busy[i_issue_rs1_addr]) ||
                    (i_issue_rs2_en && eff_busy[i_issue_rs2_addr]) ||
                    (i_issue_wd_en  && eff_busy[i_issue_wd_addr]);

    assign o_stall    = ~rst && i_issue_en && hazard;
    assign issue_fire = i_issue_en && ~o_stall && i_issue_wd_en && (i_issue_wd_addr != '0);
    assign set_vec    = issue_fire ? addr_onehot(i_issue_wd_addr) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clr_vec) | set_vec) & KEEP_MASK;
        end
    end

endmodule

// File: doc/wb_scheduler.md
WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 Parameter: RR_EN, default 1; 1 = round-robin ALU/LSU arbitration, 0 = fixed priority with LSU winning.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_issue_en  input  1  decode presents an instruction for issue this cycle.
REQ-006 i_issue_rs1_en / i_issue_rs1_addr  input  1/5  source 1 read request and address.
REQ-007 i_issue_rs2_en / i_issue_rs2_addr  input  1/5  source 2 read request and address.
REQ-008 i_issue_wd_en / i_issue_wd_addr  input  1/5  destination write intent and address.
REQ-009 o_stall  output  1  issue blocked this cycle (combinational).
REQ-010 i_alu_valid / i_alu_addr / i_alu_data  input  1/5/32  ALU writeback request.
REQ-011 o_alu_ready  output  1  ALU request granted this cycle (combinational).
REQ-012 i_lsu_valid / i_lsu_addr / i_lsu_data  input  1/5/32  LSU writeback request.
REQ-013 o_lsu_ready  output  1  LSU request granted this cycle (combinational).
REQ-014 o_wreg_en / o_wreg_addr / o_wreg_data  output  1/5/32  registered regfile write port.

Function
REQ-015 A transfer SHALL occur on a requester when valid and ready are both high at a rising edge; the requester holds valid, addr and data stable until ready.
REQ-016 At most one of o_alu_ready/o_lsu_ready SHALL be high per cycle; ready is high only when the matching valid is high.
REQ-017 With one valid requester, it SHALL be granted the same cycle.
REQ-018 With both valid and RR_EN=1, the requester not granted most recently SHALL win; the last-grant pointer updates only on a grant.
REQ-019 With both valid and RR_EN=0, LSU SHALL win.
REQ-020 Latency: a grant in cycle N SHALL drive o_wreg_en=1, o_wreg_addr and o_wreg_data from the winner in cycle N+1 for exactly one cycle.
REQ-021 Without a grant in cycle N, o_wreg_en SHALL be 0 in cycle N+1; addr/data hold their last values.
REQ-022 A granted write to address 0 SHALL be consumed (ready high) but SHALL produce o_wreg_en=0.
REQ-023 Scoreboard: 32 busy bits; busy[0] SHALL be constant 0.
REQ-024 busy[d] SHALL set at the edge where i_issue_en=1, o_stall=0, i_issue_wd_en=1 and d=i_issue_wd_addr!=0.
REQ-025 busy[a] SHALL clear at the edge where o_wreg_en=1 and a=o_wreg_addr.
REQ-026 When set and clear hit the same address in one cycle, set SHALL win.
REQ-027 Effective busy SHALL equal busy with bit o_wreg_addr masked while o_wreg_en=1 (the regfile bypasses same-cycle writes).
REQ-028 o_stall SHALL equal i_issue_en AND (rs1_en&eff[rs1] OR rs2_en&eff[rs2] OR wd_en&eff[wd]); this covers RAW and WAW hazards.
REQ-029 A writeback to a non-busy address SHALL be written normally with no side effect on other bits.
REQ-030 o_stall SHALL be 0 whenever i_issue_en=0.

Reset
REQ-031 While rst=1, o_wreg_en, o_wreg_addr and o_wreg_data SHALL be 0, all busy bits 0, and the pointer set so ALU wins the first tie.
REQ-032 o_alu_ready, o_lsu_ready and o_stall SHALL be 0 while rst=1.
REQ-033 Reset mid-operation SHALL discard any pending registered write and clear all busy bits immediately; no write is emitted after rst deasserts until a new grant.

Structure
REQ-034 Shared package SHALL hold REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32 and the requester index encoding (ALU=0, LSU=1).
REQ-035 Arbitration SHALL be a sub-module rr_arb2 (2 requests, pointer, priority mode input, one-hot grant); the scoreboard and output register stay in wb_scheduler.

Verification
REQ-036 ALU-only valid, addr=5, data=0xDEADBEEF -> o_alu_ready same cycle; next cycle o_wreg_en=1, addr=5, data=0xDEADBEEF; following cycle o_wreg_en=0.
REQ-037 Both valid for 4 cycles, RR_EN=1, after reset -> grants ALU, LSU, ALU, LSU; RR_EN=0 -> LSU for all 4 cycles.
REQ-038 Issue wd=7, then issue rs1=7 -> o_stall=1 until cycle where o_wreg_en=1, addr=7, in which o_stall=0 and busy[7] clears.
REQ-039 Same-cycle issue wd=9 (unstalled) and o_wreg_en for addr 9 -> busy[9]=1 afterward; issue wd=0 -> busy stays 0, no stall.
REQ-040 busy[3] set, ALU granted addr 3, rst pulsed in grant cycle -> o_wreg_en=0 next cycle, all busy 0, o_stall=0 for rs1=3.
